fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, shall be the instruction address width.
REQ-002 Parameter RESET_PC, default 0, shall be the PC value loaded on reset.
REQ-003 clock  input  1  shall be the single clock; all state updates occur on the rising edge.
REQ-004 reset_n  input  1  shall be an asynchronous, active-low reset.
REQ-005 start  input  1  shall be a level that, when high in S_IDLE, begins fetching at RESET_PC.
REQ-006 halt_req  input  1  shall request that fetching stop.
REQ-007 resume  input  1  shall leave S_HALT.
REQ-008 dec_ready  input  1  shall indicate that decode accepts the instruction when instr_valid is high.
REQ-009 jump_valid  input  1  shall be a redirect strobe.
REQ-010 jump_address  input  ADDR_W  shall be the redirect target.
REQ-011 pc_addr  output  ADDR_W  shall be the registered address driven to the instruction memory addra.
REQ-012 mem_en  output  1  shall be the memory read enable; the read is synchronous with 1-cycle latency.
REQ-013 instr_valid  output  1  shall indicate that douta holds a live instruction this cycle.
REQ-014 instr_pc  output  ADDR_W  shall be the address of the instruction currently on douta.
REQ-015 pc_plus_1  output  ADDR_W  shall equal instr_pc+1, modulo 2^ADDR_W.
REQ-016 fetch_count  output  16  shall count accepted instructions.
REQ-017 state  output  2  shall encode S_IDLE=0, S_RUN=1, S_STALL=2, S_HALT=3.

Function
REQ-018 States shall be S_IDLE, S_RUN, S_STALL and S_HALT.
REQ-019 S_IDLE shall transition as follows:
- mem_en=0, instr_valid=0.
- When start=1, issue RESET_PC (mem_en=1) and move to S_RUN.
REQ-020 S_RUN shall issue one fetch per cycle; at each edge with mem_en=1, pc_addr shall become pc_addr+1, wrapping 2^ADDR_W-1 to 0.
REQ-021 instr_valid shall be 1 in the cycle after an unsquashed fetch; instr_pc shall be the pc_addr registered at issue.
REQ-022 An instruction shall be accepted when instr_valid=1 and dec_ready=1; fetch_count shall increment by 1 on acceptance and wrap 0xFFFF to 0.
REQ-023 Stall: in S_RUN with instr_valid=1 and dec_ready=0, the block shall:
- go to S_STALL;
- drive mem_en=0 so douta holds its value;
- hold pc_addr;
- keep instr_valid=1 and instr_pc stable.
REQ-024 From S_STALL, dec_ready=1 shall accept the held instruction, assert mem_en=1 at pc_addr in the same cycle, and return to S_RUN with no bubble.
REQ-025 Redirect: jump_valid=1 in S_RUN or S_STALL shall take priority over stall. The block shall:
- load pc_addr=jump_address and assert mem_en at the next edge;
- force instr_valid=0 for exactly one cycle (squash of the in-flight fetch);
- not count the squashed instruction.
REQ-026 An instruction presented with instr_valid=1 in the same cycle as jump_valid=1 shall still be accepted if dec_ready=1.
REQ-027 jump_valid in S_IDLE or S_HALT shall load pc_addr only; no fetch shall be issued and the state shall not change.
REQ-028 Halt: halt_req=1 in S_RUN or S_STALL shall take effect as follows:
- halt_req shall have lower priority than jump_valid.
- From S_RUN, go to S_HALT, issue no further fetch, hold pc_addr at the next unissued address, and let the last in-flight instruction drain: instr_valid=1 until accepted.
- From S_STALL, wait until the held instruction is accepted, then go to S_HALT.
REQ-029 S_HALT with resume=1 and no instruction pending shall issue pc_addr and return to S_RUN; resume shall be ignored while an instruction is pending.
REQ-030 halt_req and resume asserted together shall be resolved as halt.
REQ-031 pc_plus_1 shall be combinational from instr_pc.

Reset
REQ-032 On reset_n=0 (asynchronous, including mid-operation), the block shall set:
- state=S_IDLE, pc_addr=RESET_PC, mem_en=0, instr_valid=0;
- instr_pc=RESET_PC, fetch_count=0.
REQ-033 After release, the block shall remain in S_IDLE until start=1; no instruction in flight before reset shall ever be reported valid.

Verification
REQ-034 The bench shall cover the following directed scenarios:
- Reset, start=1, dec_ready=1 for 5 cycles -> instr_pc 0,1,2,3 valid on consecutive cycles starting 2 edges after start; fetch_count=4.
- dec_ready=0 for 3 cycles while instr_pc=5 -> instr_valid held, instr_pc=5, pc_addr=6, mem_en=0; on release, instr_pc=6 follows next cycle.
- jump_valid with jump_address=0x200 while instr_pc=7 and dec_ready=1 -> 7 accepted, one-cycle bubble, then instr_pc=0x200, 0x201.
- pc_addr=0x3FF in S_RUN -> next issued address 0x000; pc_plus_1 for instr_pc=0x3FF is 0x000.
- halt_req during S_STALL -> held instruction delivered on dec_ready, state=S_HALT, no fetch issued; resume -> fetch continues at the next sequential PC.
- reset_n low in the middle of S_RUN -> all outputs immediately at REQ-032 values; no valid instruction after release until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch front end for a synchronous single-port instruction
//   memory with a 1-cycle read latency. It issues one sequential fetch per
//   cycle, stalls on decode back-pressure, handles jump redirects and
//   supports a halt/resume protocol.
//
// Ports
//   clock        : single clock, all state updates on the rising edge
//   reset_n      : asynchronous active-low reset
//   start        : level; in S_IDLE begins fetching at RESET_PC
//   halt_req     : request that fetching stop
//   resume       : leave S_HALT once nothing is pending
//   dec_ready    : decode accepts the instruction when instr_valid is high
//   jump_valid   : redirect strobe
//   jump_address : redirect target
//   pc_addr      : registered address to the instruction memory addra
//   mem_en       : memory read enable (combinational from state and inputs)
//   instr_valid  : douta holds a live instruction this cycle
//   instr_pc     : address of the instruction currently on douta
//   pc_plus_1    : instr_pc + 1, wrapping at 2^ADDR_W
//   fetch_count  : number of accepted instructions (wraps at 16 bits)
//   state        : FSM state, S_IDLE=0 S_RUN=1 S_STALL=2 S_HALT=3
//
// Handshake: an instruction transfers to decode on every rising edge where
// instr_valid=1 and dec_ready=1. While instr_valid=1 and dec_ready=0 the
// instruction and instr_pc are held stable (mem_en=0 keeps douta frozen);
// only a jump may discard a held instruction.

module fetch_sequencer #(
  parameter int unsigned           ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              dec_ready,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_address,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              mem_en,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus_1,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_addr_q, pc_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic accept;
  logic issue;

  assign accept = instr_valid_q & dec_ready;

  // Next-state / output logic
  always_comb begin
    state_d       = state_q;
    pc_addr_d     = pc_addr_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    issue         = 1'b0;

    // An accepted instruction is consumed; a fetch issued this cycle below
    // re-raises instr_valid for the next instruction.
    if (accept) begin
      instr_valid_d = 1'b0;
      fetch_count_d = fetch_count_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          pc_addr_d = RESET_PC;
        end else if (jump_valid) begin
          pc_addr_d = jump_address;
        end
      end

      S_RUN: begin
        if (jump_valid) begin
          // No fetch this cycle, so the next cycle is a one-cycle bubble.
          pc_addr_d     = jump_address;
          instr_valid_d = 1'b0;
        end else if (halt_req) begin
          // Any un-accepted instruction stays valid and drains in S_HALT.
          state_d = S_HALT;
        end else if (instr_valid_q && !dec_ready) begin
          state_d = S_STALL;
        end else begin
          issue = 1'b1;
        end
      end

      S_STALL: begin
        if (jump_valid) begin
          state_d       = S_RUN;
          pc_addr_d     = jump_address;
          instr_valid_d = 1'b0;
        end else if (dec_ready) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            // Refetch in the accept cycle so the pipeline has no bubble.
            state_d = S_RUN;
            issue   = 1'b1;
          end
        end
      end

      S_HALT: begin
        if (jump_valid) begin
          pc_addr_d = jump_address;
        end else if (resume && !halt_req && !instr_valid_q) begin
          state_d = S_RUN;
          issue   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      instr_valid_d = 1'b1;
      instr_pc_d    = pc_addr_q;
      pc_addr_d     = pc_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_addr_q     <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_addr_q     <= pc_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_addr     = pc_addr_q;
  assign mem_en      = issue;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus_1   = instr_pc_q + ADDR_W'(1);
  assign fetch_count = fetch_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Each table row is one clock cycle:
//   the inputs applied during that cycle and the outputs expected during the
//   same cycle (registered values plus combinational mem_en). Expected
//   outputs are pushed to a queue when the row is driven and popped when the
//   DUT outputs are sampled.

module tb_fetch_sequencer;

  localparam int ADDR_W = 10;
  localparam int EW     = 2 + ADDR_W + 1 + 1 + ADDR_W + 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic              start, halt_req, resume, dec_ready, jump_valid;
  logic [ADDR_W-1:0] jump_address;
  logic [ADDR_W-1:0] pc_addr, instr_pc, pc_plus_1;
  logic              mem_en, instr_valid;
  logic [15:0]       fetch_count;
  logic [1:0]        state;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .halt_req     (halt_req),
    .resume       (resume),
    .dec_ready    (dec_ready),
    .jump_valid   (jump_valid),
    .jump_address (jump_address),
    .pc_addr      (pc_addr),
    .mem_en       (mem_en),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .pc_plus_1    (pc_plus_1),
    .fetch_count  (fetch_count),
    .state        (state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [4:0]        in_bits;   // {start, halt_req, resume, dec_ready, jump_valid}
    logic [ADDR_W-1:0] ja;
    logic [1:0]        st;
    logic [ADDR_W-1:0] pc;
    logic              me;
    logic              iv;
    logic [ADDR_W-1:0] ipc;       // checked only when iv=1
    logic [15:0]       fc;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  logic [EW-1:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic [4:0] in_bits, input logic [ADDR_W-1:0] ja,
                              input logic [1:0] st, input logic [ADDR_W-1:0] pc,
                              input logic me, input logic iv,
                              input logic [ADDR_W-1:0] ipc, input logic [15:0] fc);
    vec_t v;
    v.in_bits = in_bits; v.ja = ja; v.st = st; v.pc = pc;
    v.me = me; v.iv = iv; v.ipc = ipc; v.fc = fc;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    start = 1'b0; halt_req = 1'b0; resume = 1'b0;
    dec_ready = 1'b0; jump_valid = 1'b0; jump_address = '0;
  endtask

  task automatic run_row(input vec_t v, input int row);
    logic [EW-1:0]     e;
    logic [1:0]        e_st;
    logic [ADDR_W-1:0] e_pc, e_ipc, e_p1;
    logic              e_me, e_iv;
    logic [15:0]       e_fc;
    @(negedge clock);
    {start, halt_req, resume, dec_ready, jump_valid} = v.in_bits;
    jump_address = v.ja;
    exp_q.push_back({v.st, v.pc, v.me, v.iv, v.ipc, v.fc});
    #1;
    e = exp_q.pop_front();
    {e_st, e_pc, e_me, e_iv, e_ipc, e_fc} = e;
    e_p1 = e_ipc + ADDR_W'(1);
    check("state",       row, 32'(state),       32'(e_st));
    check("pc_addr",     row, 32'(pc_addr),     32'(e_pc));
    check("mem_en",      row, 32'(mem_en),      32'(e_me));
    check("instr_valid", row, 32'(instr_valid), 32'(e_iv));
    check("fetch_count", row, 32'(fetch_count), 32'(e_fc));
    if (e_iv) begin
      check("instr_pc",  row, 32'(instr_pc),  32'(e_ipc));
      check("pc_plus_1", row, 32'(pc_plus_1), 32'(e_p1));
    end
  endtask

  task automatic check_reset_values(input int tag);
    check("rst_state",       tag, 32'(state),       32'd0);
    check("rst_pc_addr",     tag, 32'(pc_addr),     32'd0);
    check("rst_mem_en",      tag, 32'(mem_en),      32'd0);
    check("rst_instr_valid", tag, 32'(instr_valid), 32'd0);
    check("rst_instr_pc",    tag, 32'(instr_pc),    32'd0);
    check("rst_fetch_count", tag, 32'(fetch_count), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Main directed run: start, stall, jump, wrap, halt in stall,
    // halt drain from run, jump in halt, halt+resume, jump during stall.
    //              in        ja      st pc      me iv ipc     fc
    tbl_a.push_back(mk(5'b00000, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0));
    tbl_a.push_back(mk(5'b10010, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h000, 1, 0, 10'h000, 0));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h001, 1, 1, 10'h000, 0));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h002, 1, 1, 10'h001, 1));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h003, 1, 1, 10'h002, 2));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h004, 1, 1, 10'h003, 3));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h005, 1, 1, 10'h004, 4));
    tbl_a.push_back(mk(5'b00000, 10'h000, 1, 10'h006, 0, 1, 10'h005, 5));
    tbl_a.push_back(mk(5'b00000, 10'h000, 2, 10'h006, 0, 1, 10'h005, 5));
    tbl_a.push_back(mk(5'b00000, 10'h000, 2, 10'h006, 0, 1, 10'h005, 5));
    tbl_a.push_back(mk(5'b00010, 10'h000, 2, 10'h006, 1, 1, 10'h005, 5));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h007, 1, 1, 10'h006, 6));
    tbl_a.push_back(mk(5'b00011, 10'h200, 1, 10'h008, 0, 1, 10'h007, 7));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h200, 1, 0, 10'h000, 8));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h201, 1, 1, 10'h200, 8));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h202, 1, 1, 10'h201, 9));
    tbl_a.push_back(mk(5'b00011, 10'h3FE, 1, 10'h203, 0, 1, 10'h202, 10));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h3FE, 1, 0, 10'h000, 11));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h3FF, 1, 1, 10'h3FE, 11));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h000, 1, 1, 10'h3FF, 12));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h001, 1, 1, 10'h000, 13));
    tbl_a.push_back(mk(5'b00000, 10'h000, 1, 10'h002, 0, 1, 10'h001, 14));
    tbl_a.push_back(mk(5'b01000, 10'h000, 2, 10'h002, 0, 1, 10'h001, 14));
    tbl_a.push_back(mk(5'b01010, 10'h000, 2, 10'h002, 0, 1, 10'h001, 14));
    tbl_a.push_back(mk(5'b00010, 10'h000, 3, 10'h002, 0, 0, 10'h000, 15));
    tbl_a.push_back(mk(5'b00110, 10'h000, 3, 10'h002, 1, 0, 10'h000, 15));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h003, 1, 1, 10'h002, 15));
    tbl_a.push_back(mk(5'b01000, 10'h000, 1, 10'h004, 0, 1, 10'h003, 16));
    tbl_a.push_back(mk(5'b00100, 10'h000, 3, 10'h004, 0, 1, 10'h003, 16));
    tbl_a.push_back(mk(5'b00010, 10'h000, 3, 10'h004, 0, 1, 10'h003, 16));
    tbl_a.push_back(mk(5'b00001, 10'h100, 3, 10'h004, 0, 0, 10'h000, 17));
    tbl_a.push_back(mk(5'b01100, 10'h000, 3, 10'h100, 0, 0, 10'h000, 17));
    tbl_a.push_back(mk(5'b00100, 10'h000, 3, 10'h100, 1, 0, 10'h000, 17));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h101, 1, 1, 10'h100, 17));
    tbl_a.push_back(mk(5'b00000, 10'h000, 1, 10'h102, 0, 1, 10'h101, 18));
    tbl_a.push_back(mk(5'b00001, 10'h050, 2, 10'h102, 0, 1, 10'h101, 18));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h050, 1, 0, 10'h000, 18));
    tbl_a.push_back(mk(5'b00010, 10'h000, 1, 10'h051, 1, 1, 10'h050, 18));

    // After a mid-run reset: idle until start, jump in idle loads pc only,
    // start refetches from RESET_PC.
    tbl_b.push_back(mk(5'b00010, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0));
    tbl_b.push_back(mk(5'b00011, 10'h030, 0, 10'h000, 0, 0, 10'h000, 0));
    tbl_b.push_back(mk(5'b00010, 10'h000, 0, 10'h030, 0, 0, 10'h000, 0));
    tbl_b.push_back(mk(5'b10010, 10'h000, 0, 10'h030, 0, 0, 10'h000, 0));
    tbl_b.push_back(mk(5'b00010, 10'h000, 1, 10'h000, 1, 0, 10'h000, 0));
    tbl_b.push_back(mk(5'b00010, 10'h000, 1, 10'h001, 1, 1, 10'h000, 0));
    tbl_b.push_back(mk(5'b00010, 10'h000, 1, 10'h002, 1, 1, 10'h001, 1));

    // Power-on reset
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clock);
    #1;
    check_reset_values(0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl_a.size(); i++) run_row(tbl_a[i], i);

    // Asynchronous reset in the middle of a running cycle
    @(posedge clock);
    #2;
    drive_idle();
    dec_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    check_reset_values(1);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < tbl_b.size(); i++) run_row(tbl_b[i], 100 + i);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
